serial_addsub: RTL and testbench

//   Parametrised multi-cycle adder/subtractor: ripples a WIDTH-bit add or subtract

---
 rtl/serial_addsub_pkg.sv | 21 ++
 rtl/serial_addsub_slice.sv | 34 +++
 rtl/serial_addsub.sv | 139 +++++++++++++
 tb/tb_serial_addsub.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_t : FSM state encoding (idle, slice processing, one-cycle done).
//   clog2   : ceiling log2, used to size the slice index register.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_slice.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Ports:
//   a, b      in   DIGIT  slice operands (b already conditioned for subtract)
//   ci        in   1      carry into the slice LSB
//   s         out  DIGIT  slice sum
//   co        out  1      carry out of the slice MSB
//   c_msb_in  out  1      carry into the slice MSB (for signed overflow)
module serial_addsub_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT - 1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: processes a WIDTH-bit add or subtract one
// DIGIT-bit slice per clock with a registered carry between slices.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     request, accepted in IDLE or DONE
//   sub       0 = add (a + b + ci), 1 = subtract (a - b - ci)
//   a, b, ci  operands and carry/borrow-in, sampled on accept
//   busy      high while slices are being processed
//   done      one-cycle pulse; f/co/ovf/zero valid from this cycle
//   f         result, held until the next accepted start
//   co        raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf       two's-complement signed overflow
//   zero      f == 0
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_addsub: illegal WIDTH/DIGIT combination");
    end

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] f_r;
    logic [WIDTH-1:0] f_next;
    logic             carry;
    logic             co_r;
    logic             ovf_r;
    logic             zero_r;
    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT-1:0] s_sl;
    logic             s_co;
    logic             s_cmsb;
    logic             accept;
    logic             last;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = (state == S_RUN) && (idx == LAST);

    // Select the current slice of the held operands and splice its sum
    // into the result word.
    always_comb begin
        a_sl   = a_r[int'(idx) * DIGIT +: DIGIT];
        b_sl   = b_r[int'(idx) * DIGIT +: DIGIT];
        f_next = f_r;
        f_next[int'(idx) * DIGIT +: DIGIT] = s_sl;
    end

    serial_addsub_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a        (a_sl),
        .b        (b_sl),
        .ci       (carry),
        .s        (s_sl),
        .co       (s_co),
        .c_msb_in (s_cmsb)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            f_r    <= '0;
            co_r   <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                idx <= '0;
            end else if (state == S_RUN) begin
                idx <= idx + 1'b1;
                f_r <= f_next;
                if (last) begin
                    co_r   <= s_co;
                    ovf_r  <= s_co ^ s_cmsb;
                    zero_r <= ~|f_next;
                end
            end
        end
    end

    // Operand and inter-slice carry registers. Subtraction is formed as
    // A + ~B + ~ci, so B and the carry-in are conditioned once at accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            carry <= ci ^ sub;
        end else if (state == S_RUN) begin
            carry <= s_co;
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign f    = f_r;
    assign co   = co_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three 8-bit instances (DIGIT=2, 1, 8) share one
// stimulus stream. A cycle-count/arithmetic model predicts busy, done and the
// held results; directed operations are also pinned by literal values.
module tb_serial_addsub;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;

    logic       busy_o [3];
    logic       done_o [3];
    logic [7:0] f_o    [3];
    logic       co_o   [3];
    logic       ovf_o  [3];
    logic       zero_o [3];

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_o[0]), .done(done_o[0]), .f(f_o[0]), .co(co_o[0]),
        .ovf(ovf_o[0]), .zero(zero_o[0]));

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_o[1]), .done(done_o[1]), .f(f_o[1]), .co(co_o[1]),
        .ovf(ovf_o[1]), .zero(zero_o[1]));

    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_o[2]), .done(done_o[2]), .f(f_o[2]), .co(co_o[2]),
        .ovf(ovf_o[2]), .zero(zero_o[2]));

    function automatic int nsl(input int j);
        return (j == 0) ? 4 : ((j == 1) ? 8 : 1);
    endfunction

    // Returns {ovf, co, f} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic s, input logic [7:0] x,
                                         input logic [7:0] y, input logic c);
        int u;
        int v;
        logic cy;
        logic ov;
        if (s) begin
            u  = int'(x) - int'(y) - int'(c);
            v  = int'($signed(x)) - int'($signed(y)) - int'(c);
            cy = (u >= 0);
        end else begin
            u  = int'(x) + int'(y) + int'(c);
            v  = int'($signed(x)) + int'($signed(y)) + int'(c);
            cy = (u > 255);
        end
        ov = (v < -128) || (v > 127);
        return {ov, cy, u[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: per instance, remaining slice cycles and held results.
    int         cnt    [3];
    logic       m_done [3];
    logic [7:0] m_f    [3];
    logic       m_co   [3];
    logic       m_ovf  [3];
    logic       m_zero [3];
    logic [9:0] pend   [3];

    always @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (rst) begin
                cnt[j]    <= 0;
                m_done[j] <= 1'b0;
                m_f[j]    <= 8'h00;
                m_co[j]   <= 1'b0;
                m_ovf[j]  <= 1'b0;
                m_zero[j] <= 1'b1;
            end else if (cnt[j] > 0) begin
                cnt[j]    <= cnt[j] - 1;
                m_done[j] <= (cnt[j] == 1);
                if (cnt[j] == 1) begin
                    m_f[j]    <= pend[j][7:0];
                    m_co[j]   <= pend[j][8];
                    m_ovf[j]  <= pend[j][9];
                    m_zero[j] <= (pend[j][7:0] == 8'h00);
                end
            end else begin
                m_done[j] <= 1'b0;
                if (start) begin
                    cnt[j]  <= nsl(j);
                    pend[j] <= model(sub, a, b, ci);
                end
            end
        end
    end

    // Compare process: handshake every cycle, results whenever not running.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("busy[%0d]", j), busy_o[j], cnt[j] > 0);
                chk($sformatf("done[%0d]", j), done_o[j], m_done[j]);
                if (cnt[j] == 0) begin
                    chk($sformatf("f[%0d]", j), f_o[j], m_f[j]);
                    chk($sformatf("co[%0d]", j), co_o[j], m_co[j]);
                    chk($sformatf("ovf[%0d]", j), ovf_o[j], m_ovf[j]);
                    chk($sformatf("zero[%0d]", j), zero_o[j], m_zero[j]);
                end
            end
        end
    end

    // One operation on all instances; checks latency and literal results.
    task automatic run_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic [7:0] ef, input logic eco,
                          input logic eov, input logic ez);
        int lat;
        bit seen [3];
        seen = '{0, 0, 0};
        @(posedge clk); #1;
        sub = s; a = x; b = y; ci = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!(seen[0] && seen[1] && seen[2]) && lat < 20) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (!seen[j] && done_o[j]) begin
                    seen[j] = 1;
                    chk($sformatf("lat[%0d]", j), lat, nsl(j));
                    chk($sformatf("lit_f[%0d]", j), f_o[j], ef);
                    chk($sformatf("lit_co[%0d]", j), co_o[j], eco);
                    chk($sformatf("lit_ovf[%0d]", j), ovf_o[j], eov);
                    chk($sformatf("lit_zero[%0d]", j), zero_o[j], ez);
                end
            end
            lat++;
        end
        for (int j = 0; j < 3; j++)
            if (!seen[j]) chk($sformatf("done_timeout[%0d]", j), 0, 1);
    endtask

    initial begin
        int   k;
        int   ndone;
        bit   seen [3];

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; ci = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_f", f_o[0], 8'h00);
        chk("rst_zero", zero_o[0], 1'b1);
        chk("rst_co", co_o[0], 1'b0);
        chk("rst_ovf", ovf_o[0], 1'b0);
        chk("rst_busy", busy_o[0], 1'b0);
        chk("rst_done", done_o[0], 1'b0);

        run_op(1'b0, 8'h3C, 8'h4B, 1'b0, 8'h87, 1'b0, 1'b1, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 8'h05, 8'h07, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Start while busy, then reset mid-operation.
        @(posedge clk); #1;
        sub = 1'b0; a = 8'h3C; b = 8'h4B; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_f", f_o[0], 8'h00);
        chk("abort_zero", zero_o[0], 1'b1);
        chk("abort_busy", busy_o[0], 1'b0);
        chk("abort_f8", f_o[1], 8'h00);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_o[0] || done_o[1]) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Same sequence without reset: the first operation completes.
        @(posedge clk); #1;
        sub = 1'b0; a = 8'h3C; b = 8'h4B; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = '{0, 0, 0};
        k = 0;
        while (!(seen[0] && seen[1]) && k < 20) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (!seen[j] && done_o[j]) begin
                    seen[j] = 1;
                    chk($sformatf("busy_ign_f[%0d]", j), f_o[j], 8'h87);
                    chk($sformatf("busy_ign_ovf[%0d]", j), ovf_o[j], 1'b1);
                end
            end
            k++;
        end
        for (int j = 0; j < 2; j++)
            if (!seen[j]) chk($sformatf("busy_ign_timeout[%0d]", j), 0, 1);
        repeat (10) @(posedge clk);

        // Back-to-back: start asserted during the DONE cycle of the DIGIT=2 unit.
        #1;
        sub = 1'b1; a = 8'h05; b = 8'h07; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (!done_o[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_first_done", done_o[0], 1'b1);
        chk("b2b_first_f", f_o[0], 8'hFE);
        sub = 1'b0; a = 8'hFF; b = 8'h01; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", busy_o[0], 1'b1);
        k = 1;
        while (!done_o[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_gap", k, 5);
        chk("b2b_f", f_o[0], 8'h00);
        chk("b2b_co", co_o[0], 1'b1);
        chk("b2b_zero", zero_o[0], 1'b1);

        repeat (12) @(posedge clk);
        @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
